// File: rtl/rtp_audio_depack.sv
// rtp_audio_depack: validates RTP/L16 packets from the UDP receive stream and
// unpacks big-endian 16-bit samples into a playback jitter FIFO.
// Optional feature macro: RTP_SEQ_CHECK_EN (sequence tracking, stale drop, loss count).
module rtp_audio_depack #(
    parameter logic [15:0] RTP_Header_Param = 16'h8080,
    parameter logic [31:0] SSRC             = 32'h12345678,
    parameter int unsigned FIFO_AW          = 10,
    parameter int unsigned PREFILL          = 474
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               udp_rec_data_valid,
    input  logic [7:0]         udp_rec_rdata,
    input  logic [15:0]        udp_rec_data_length,
    input  logic               wav_rden,
    output logic [15:0]        wav_out_data,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               playing,
    output logic [15:0]        pkt_ok_cnt,
    output logic [15:0]        pkt_drop_cnt,
    output logic [15:0]        underflow_cnt,
    output logic [15:0]        overflow_cnt,
    output logic [15:0]        lost_cnt
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISCARD} state_t;

    state_t             state_q, state_d;
    logic [15:0]        idx_q;          // index of the next byte within the packet
    logic [15:0]        len_q;
    logic [7:0]         hi_q;
    logic               push_q;
    logic [15:0]        push_data_q;
    logic [15:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;

    logic               last_c, hdr_ok_c, seq_ok_c, drop_c, ok_c, push_c;
    logic               pop_c, underflow_c, full_c, wr_c;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign last_c = (idx_q == len_q - 16'd1);

`ifdef RTP_SEQ_CHECK_EN
    logic [15:0] seq_q, last_seq_q, seq_diff_c;
    logic        armed_q;
    logic [16:0] lost_sum_c;

    assign seq_diff_c = seq_q - last_seq_q;
    assign seq_ok_c   = !armed_q || ((seq_diff_c != 16'd0) && !seq_diff_c[15]);
    assign lost_sum_c = {1'b0, lost_cnt} + {1'b0, seq_diff_c - 16'd1};

    // Sequence capture, tracker update on acceptance, lost-packet accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q      <= '0;
            last_seq_q <= '0;
            armed_q    <= 1'b0;
            lost_cnt   <= '0;
        end else begin
            if (udp_rec_data_valid && state_q == HDR) begin
                if (idx_q == 16'd2) seq_q[15:8] <= udp_rec_rdata;
                if (idx_q == 16'd3) seq_q[7:0]  <= udp_rec_rdata;
            end
            if (state_q == HDR && state_d == PAYLOAD) begin
                last_seq_q <= seq_q;
                armed_q    <= 1'b1;
                if (armed_q && seq_diff_c > 16'd1)
                    lost_cnt <= lost_sum_c[16] ? 16'hFFFF : lost_sum_c[15:0];
            end
        end
    end
`else
    assign seq_ok_c = 1'b1;
    assign lost_cnt = 16'd0;
`endif

    // Parser next-state: header checks, payload byte steering, drop/accept events
    always_comb begin
        state_d  = state_q;
        drop_c   = 1'b0;
        ok_c     = 1'b0;
        push_c   = 1'b0;
        hdr_ok_c = 1'b1;
        case (idx_q)
            16'd1:   hdr_ok_c = (udp_rec_rdata == RTP_Header_Param[7:0]);
            16'd8:   hdr_ok_c = (udp_rec_rdata == SSRC[31:24]);
            16'd9:   hdr_ok_c = (udp_rec_rdata == SSRC[23:16]);
            16'd10:  hdr_ok_c = (udp_rec_rdata == SSRC[15:8]);
            16'd11:  hdr_ok_c = (udp_rec_rdata == SSRC[7:0]);
            default: hdr_ok_c = 1'b1;
        endcase
        if (udp_rec_data_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (udp_rec_data_length < 16'd14 || udp_rec_data_length[0] ||
                        udp_rec_rdata != RTP_Header_Param[15:8]) begin
                        drop_c  = 1'b1;
                        state_d = (udp_rec_data_length <= 16'd1) ? IDLE : DISCARD;
                    end else begin
                        state_d = HDR;
                    end
                end
                HDR: begin
                    if (!hdr_ok_c) begin
                        drop_c  = 1'b1;
                        state_d = DISCARD;
                    end else if (idx_q == 16'd11) begin
                        if (seq_ok_c) begin
                            state_d = PAYLOAD;
                        end else begin
                            drop_c  = 1'b1;
                            state_d = DISCARD;
                        end
                    end
                end
                PAYLOAD: begin
                    push_c = idx_q[0];
                    if (last_c) begin
                        ok_c    = 1'b1;
                        state_d = IDLE;
                    end
                end
                DISCARD: begin
                    if (last_c) state_d = IDLE;
                end
            endcase
        end
    end

    // Parser state, byte index, length latch and sample assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            hi_q        <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= push_c;
            if (udp_rec_data_valid) begin
                if (state_d == IDLE)      idx_q <= '0;
                else if (state_q == IDLE) idx_q <= 16'd1;
                else                      idx_q <= idx_q + 16'd1;
                if (state_q == IDLE) len_q <= udp_rec_data_length;
                if (state_q == PAYLOAD && !idx_q[0]) hi_q <= udp_rec_rdata;
                if (push_c) push_data_q <= {hi_q, udp_rec_rdata};
            end
        end
    end

    // Packet counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (ok_c)   pkt_ok_cnt   <= sat_inc(pkt_ok_cnt);
            if (drop_c) pkt_drop_cnt <= sat_inc(pkt_drop_cnt);
        end
    end

    assign pop_c       = wav_rden && playing && (fifo_level != '0);
    assign underflow_c = wav_rden && playing && (fifo_level == '0);
    assign full_c      = (fifo_level == LW'(DEPTH));
    assign wr_c        = push_q && (!full_c || pop_c);

    // Sample storage; a write at full is allowed only alongside a pop
    always_ff @(posedge clk) begin
        if (wr_c) mem[wr_ptr_q] <= push_data_q;
    end

    // FIFO pointers/level, playback output, prefill gate, overflow/underflow counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_level    <= '0;
            wav_out_data  <= '0;
            playing       <= 1'b0;
            underflow_cnt <= '0;
            overflow_cnt  <= '0;
        end else begin
            if (wr_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (push_q && !wr_c) overflow_cnt <= sat_inc(overflow_cnt);
            if (pop_c) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            case ({wr_c, pop_c})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (wav_rden) wav_out_data <= pop_c ? mem[rd_ptr_q] : 16'h0000;
            if (underflow_c) begin
                underflow_cnt <= sat_inc(underflow_cnt);
                playing       <= 1'b0;
            end else if (32'(fifo_level) >= PREFILL) begin
                playing <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rtp_audio_depack.sv
// Self-checking bench for rtp_audio_depack (FIFO_AW=2, PREFILL=2).
module tb_rtp_audio_depack;

    localparam int DEPTH   = 4;
    localparam int PREFILL = 2;

    logic        clk, rst_n;
    logic        udp_rec_data_valid;
    logic [7:0]  udp_rec_rdata;
    logic [15:0] udp_rec_data_length;
    logic        wav_rden;
    logic [15:0] wav_out_data;
    logic [2:0]  fifo_level;
    logic        playing;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt, underflow_cnt, overflow_cnt, lost_cnt;

    rtp_audio_depack #(
        .RTP_Header_Param(16'h8080),
        .SSRC(32'h12345678),
        .FIFO_AW(2),
        .PREFILL(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .udp_rec_data_valid(udp_rec_data_valid),
        .udp_rec_rdata(udp_rec_rdata),
        .udp_rec_data_length(udp_rec_data_length),
        .wav_rden(wav_rden),
        .wav_out_data(wav_out_data),
        .fifo_level(fifo_level),
        .playing(playing),
        .pkt_ok_cnt(pkt_ok_cnt),
        .pkt_drop_cnt(pkt_drop_cnt),
        .underflow_cnt(underflow_cnt),
        .overflow_cnt(overflow_cnt),
        .lost_cnt(lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b11;
        logic [15:0] len;
        logic [15:0] seq;
        logic [15:0] s0;
        logic [15:0] s1;
        bit          acc;
    } vec_t;

    vec_t        vt[8];
    vec_t        sq[4];
    logic [15:0] exp_q[$];
    bit          m_play;
    int          m_uf, m_ovf, e_ok, e_drop;
    int          n_tests, n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [15:0] samp(input vec_t v, input int k);
        case (k % 4)
            0:       return v.s0;
            1:       return v.s1;
            2:       return ~v.s0;
            default: return ~v.s1;
        endcase
    endfunction

    function automatic logic [7:0] pkt_byte(input vec_t v, input int i);
        logic [15:0] s;
        case (i)
            0:  return v.b0;
            1:  return 8'h80;
            2:  return v.seq[15:8];
            3:  return v.seq[7:0];
            8:  return 8'h12;
            9:  return 8'h34;
            10: return 8'h56;
            11: return v.b11;
            default: ;
        endcase
        if (i < 12) return 8'h00;
        s = samp(v, (i - 12) / 2);
        return ((i % 2) == 0) ? s[15:8] : s[7:0];
    endfunction

    task automatic model_pop(output logic [15:0] e);
        if (m_play && exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = 16'h0000;
            if (m_play) begin
                m_uf++;
                m_play = 1'b0;
            end
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_play = 1'b0;
        m_uf = 0; m_ovf = 0; e_ok = 0; e_drop = 0;
    endtask

    task automatic pop_check(input string name);
        logic [15:0] e;
        @(negedge clk);
        wav_rden = 1'b1;
        model_pop(e);
        @(negedge clk);
        wav_rden = 1'b0;
        check(name, 32'(wav_out_data), 32'(e));
    endtask

    task automatic check_counts(input string name);
        check({name, "_ok"},    32'(pkt_ok_cnt),   32'(e_ok));
        check({name, "_drop"},  32'(pkt_drop_cnt), 32'(e_drop));
        check({name, "_level"}, 32'(fifo_level),   32'(exp_q.size()));
    endtask

    // Sends one packet (gap after byte 6); optionally pops in the cycle the last sample lands
    task automatic send_pkt(input vec_t v, input bit pop_at_end);
        logic [15:0] e;
        e = 16'h0000;
        for (int i = 0; i < int'(v.len); i++) begin
            @(negedge clk);
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = pkt_byte(v, i);
            udp_rec_data_length = v.len;
            if (i == 6) begin
                @(negedge clk);
                udp_rec_data_valid = 1'b0;
            end
        end
        @(negedge clk);
        udp_rec_data_valid = 1'b0;
        wav_rden = pop_at_end;
        if (pop_at_end) model_pop(e);
        if (v.acc) begin
            for (int k = 0; k < (int'(v.len) - 12) / 2; k++) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(samp(v, k));
                else m_ovf++;
            end
        end
        @(negedge clk);
        wav_rden = 1'b0;
        if (pop_at_end) check("conc_pop_data", 32'(wav_out_data), 32'(e));
        repeat (2) @(negedge clk);
        if (v.acc) e_ok++;
        else e_drop++;
        if (exp_q.size() >= PREFILL) m_play = 1'b1;
    endtask

    task automatic do_reset();
        udp_rec_data_valid = 1'b0;
        wav_rden = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_model();
    endtask

    initial begin
        vec_t v;
        n_tests = 0; n_fail = 0;
        udp_rec_rdata = 8'h00; udp_rec_data_length = 16'd0;
        //        b0     b11    len     seq     s0        s1        acc
        vt[0] = '{8'h80, 8'h78, 16'd16, 16'd1, 16'h1234, 16'hABCD, 1'b1};
        vt[1] = '{8'h80, 8'h79, 16'd16, 16'd9, 16'h1234, 16'hABCD, 1'b0};
        vt[2] = '{8'h80, 8'h78, 16'd15, 16'd9, 16'h1234, 16'hABCD, 1'b0};
        vt[3] = '{8'h90, 8'h78, 16'd16, 16'd9, 16'h1234, 16'hABCD, 1'b0};
        vt[4] = '{8'h80, 8'h78, 16'd12, 16'd9, 16'h1234, 16'hABCD, 1'b0};
        vt[5] = '{8'h80, 8'h78, 16'd20, 16'd2, 16'h1111, 16'h2222, 1'b1};
        vt[6] = '{8'h80, 8'h78, 16'd20, 16'd3, 16'h3333, 16'h4444, 1'b1};
        vt[7] = '{8'h80, 8'h78, 16'd14, 16'd4, 16'h5555, 16'h6666, 1'b1};
`ifdef RTP_SEQ_CHECK_EN
        sq[0] = '{8'h80, 8'h78, 16'd14, 16'd5, 16'h0505, 16'h0000, 1'b1};
        sq[1] = '{8'h80, 8'h78, 16'd14, 16'd8, 16'h0808, 16'h0000, 1'b1};
        sq[2] = '{8'h80, 8'h78, 16'd14, 16'd8, 16'h0888, 16'h0000, 1'b0};
        sq[3] = '{8'h80, 8'h78, 16'd14, 16'd7, 16'h0707, 16'h0000, 1'b0};
`else
        sq[0] = '{8'h80, 8'h78, 16'd14, 16'd5, 16'h0505, 16'h0000, 1'b1};
        sq[1] = '{8'h80, 8'h78, 16'd14, 16'd8, 16'h0808, 16'h0000, 1'b1};
        sq[2] = '{8'h80, 8'h78, 16'd14, 16'd8, 16'h0888, 16'h0000, 1'b1};
        sq[3] = '{8'h80, 8'h78, 16'd14, 16'd7, 16'h0707, 16'h0000, 1'b1};
`endif
        do_reset();

        check("rst_wav",   32'(wav_out_data),  32'h0);
        check("rst_level", 32'(fifo_level),    32'h0);
        check("rst_play",  32'(playing),       32'h0);
        check("rst_ok",    32'(pkt_ok_cnt),    32'h0);
        check("rst_drop",  32'(pkt_drop_cnt),  32'h0);
        check("rst_uf",    32'(underflow_cnt), 32'h0);
        check("rst_ovf",   32'(overflow_cnt),  32'h0);
        check("rst_lost",  32'(lost_cnt),      32'h0);

        // Good packet, then SSRC / odd length / byte 0 / short-length drops
        for (int i = 0; i <= 4; i++) begin
            send_pkt(vt[i], 1'b0);
            check_counts($sformatf("v%0d", i));
        end
        check("play_after_prefill", 32'(playing), 32'(m_play));

        pop_check("pop0_data");
        pop_check("pop1_data");
        check("drained_level", 32'(fifo_level), 32'(exp_q.size()));
        pop_check("uf_data");
        check("uf_cnt1",  32'(underflow_cnt), 32'(m_uf));
        check("uf_play",  32'(playing),       32'(m_play));
        pop_check("idle_pop_data");
        check("uf_cnt_hold", 32'(underflow_cnt), 32'(m_uf));

        // Overflow: two 4-sample packets without pops
        for (int i = 5; i <= 6; i++) begin
            send_pkt(vt[i], 1'b0);
            check_counts($sformatf("v%0d", i));
        end
        check("ovf_cnt",   32'(overflow_cnt), 32'(m_ovf));
        check("ovf_play",  32'(playing),      32'(m_play));

        // Push and pop in the same cycle at full
        send_pkt(vt[7], 1'b1);
        check("conc_level", 32'(fifo_level),   32'(exp_q.size()));
        check("conc_ovf",   32'(overflow_cnt), 32'(m_ovf));
        for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
        check("drain_level", 32'(fifo_level), 32'(exp_q.size()));

        // Sequence tracking
        do_reset();
        for (int i = 0; i < 4; i++) send_pkt(sq[i], 1'b0);
        check_counts("seq");
`ifdef RTP_SEQ_CHECK_EN
        check("seq_lost", 32'(lost_cnt), 32'd2);
`else
        check("seq_lost", 32'(lost_cnt), 32'd0);
`endif

        // Reset pulse in the middle of the payload
        v = vt[0];
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = pkt_byte(v, i);
            udp_rec_data_length = v.len;
        end
        @(negedge clk);
        udp_rec_data_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        check("mid_rst_ok",    32'(pkt_ok_cnt),    32'h0);
        check("mid_rst_drop",  32'(pkt_drop_cnt),  32'h0);
        check("mid_rst_level", 32'(fifo_level),    32'h0);
        check("mid_rst_lost",  32'(lost_cnt),      32'h0);
        check("mid_rst_ovf",   32'(overflow_cnt),  32'h0);
        for (int i = 13; i <= 15; i++) begin
            @(negedge clk);
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = pkt_byte(v, i);
            udp_rec_data_length = 16'd3;
        end
        @(negedge clk);
        udp_rec_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        e_drop++;
        check_counts("remnant");
        send_pkt(vt[0], 1'b0);
        check_counts("after_rst");
        pop_check("after_rst_pop0");
        pop_check("after_rst_pop1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
